// File: rtl/sram_pixel_streamer.sv
// Streams a frame from SRAM as two header beats (width, height) followed by RGB888 pixels.
// Words are prefetched into a small FIFO. Read credits bound occupancy plus in-flight reads to FIFO_DEPTH.
module sram_pixel_streamer #(
  parameter int AW         = 20,
  parameter int DW         = 16,
  parameter int START_ADDR = 0,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [15:0]   img_w,
  input  logic [15:0]   img_h,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  output logic          rd_en,
  input  logic [DW-1:0] rdata,
  output logic          vgastart,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          px_header,
  output logic          px_last,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] BASE = AW'(START_ADDR);

  typedef enum logic [2:0] {IDLE, HDR_W, HDR_H, PIX, DONE} state_e;

  state_e            state_q;
  logic              mode_q;
  logic [15:0]       h_q;
  logic [31:0]       n_q, pix_q;
  logic [32:0]       wc_q, issued_q;
  logic [DW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q, tot_q;
  logic [RD_LAT-1:0] vsr_q;

  logic [31:0]   n_d;
  logic [32:0]   wc_d;
  logic [DW-1:0] w_hd, w_nx;
  logic [7:0]    pr, pg, pb;
  logic [1:0]    npop, pops;
  logic          can_load, pix_last, fire, free, in_pix, load_pix, issue, push;

  assign n_d  = 32'(img_w) * 32'(img_h);
  assign wc_d = mode ? 33'(n_d) : 33'((34'(n_d) * 34'd3 + 34'd1) >> 1);

  assign w_hd     = mem_q[rp_q];
  assign w_nx     = mem_q[rp_q + PW'(1)];
  assign pix_last = (pix_q == n_q - 32'd1);
  assign fire     = px_valid & px_ready;
  assign free     = ~px_valid | px_ready;
  assign in_pix   = (state_q == PIX) | ((state_q == HDR_H) & (n_q != 32'd0));
  assign load_pix = in_pix & free & (pix_q < n_q) & can_load;
  assign pops     = load_pix ? npop : 2'd0;
  assign issue    = (state_q inside {HDR_W, HDR_H, PIX}) & (issued_q < wc_q) &
                    (tot_q < CW'(FIFO_DEPTH));
  assign push     = vsr_q[RD_LAT-1];

  // Packed RGB888 alternates: even pixel consumes w0 and peeks w1, odd pixel consumes w1,w2.
  always_comb begin
    pr = 8'd0;
    pg = 8'd0;
    pb = 8'd0;
    can_load = 1'b0;
    npop = 2'd0;
    if (mode_q) begin
      pr = {w_hd[15:11], w_hd[15:13]};
      pg = {w_hd[10:5], w_hd[10:9]};
      pb = {w_hd[4:0], w_hd[4:2]};
      can_load = (cnt_q != '0);
      npop = 2'd1;
    end else if (!pix_q[0]) begin
      pr = w_hd[7:0];
      pg = w_hd[15:8];
      pb = w_nx[7:0];
      can_load = (cnt_q >= CW'(2));
      npop = pix_last ? 2'd2 : 2'd1;
    end else begin
      pr = w_hd[15:8];
      pg = w_nx[7:0];
      pb = w_nx[15:8];
      can_load = (cnt_q >= CW'(2));
      npop = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vgastart  <= 1'b0;
      rd_en     <= 1'b0;
      raddr     <= BASE;
      px_valid  <= 1'b0;
      px_header <= 1'b0;
      px_last   <= 1'b0;
      r         <= 8'd0;
      g         <= 8'd0;
      b         <= 8'd0;
      mode_q    <= 1'b0;
      h_q       <= 16'd0;
      n_q       <= 32'd0;
      pix_q     <= 32'd0;
      wc_q      <= 33'd0;
      issued_q  <= 33'd0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      tot_q     <= '0;
      vsr_q     <= '0;
    end else if (abort && state_q != IDLE) begin
      // Returns still in flight are dropped by clearing the valid shift register.
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vgastart  <= 1'b0;
      rd_en     <= 1'b0;
      px_valid  <= 1'b0;
      px_header <= 1'b0;
      px_last   <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      tot_q     <= '0;
      vsr_q     <= '0;
    end else begin
      done     <= 1'b0;
      vgastart <= 1'b0;
      rd_en    <= issue;
      vsr_q    <= (vsr_q << 1) | RD_LAT'(rd_en);
      if (issue) begin
        raddr    <= BASE + issued_q[AW-1:0];
        issued_q <= issued_q + 33'd1;
      end
      if (push) wp_q <= wp_q + PW'(1);
      rp_q  <= rp_q + PW'(pops);
      cnt_q <= cnt_q + CW'(push) - CW'(pops);
      tot_q <= tot_q + CW'(issue) - CW'(pops);

      case (state_q)
        IDLE: if (start) begin
          state_q   <= HDR_W;
          busy      <= 1'b1;
          vgastart  <= 1'b1;
          mode_q    <= mode;
          h_q       <= img_h;
          n_q       <= n_d;
          wc_q      <= wc_d;
          issued_q  <= 33'd0;
          pix_q     <= 32'd0;
          px_valid  <= 1'b1;
          px_header <= 1'b1;
          px_last   <= 1'b0;
          r         <= img_w[7:0];
          g         <= img_w[15:8];
          b         <= 8'd0;
        end
        HDR_W: if (fire) begin
          state_q <= HDR_H;
          r       <= h_q[7:0];
          g       <= h_q[15:8];
          b       <= 8'd0;
          px_last <= (n_q == 32'd0);
        end
        HDR_H: if (fire) begin
          if (n_q == 32'd0) begin
            state_q   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            px_valid  <= 1'b0;
            px_header <= 1'b0;
            px_last   <= 1'b0;
          end else begin
            state_q <= PIX;
          end
        end
        PIX: if (fire && px_last) begin
          state_q <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // The output register refills only when empty or being accepted; underflow yields a gap, never a bubble beat.
      if (load_pix) begin
        px_valid  <= 1'b1;
        px_header <= 1'b0;
        px_last   <= pix_last;
        r         <= pr;
        g         <= pg;
        b         <= pb;
        pix_q     <= pix_q + 32'd1;
      end else if (in_pix && free) begin
        px_valid  <= 1'b0;
        px_header <= 1'b0;
        px_last   <= 1'b0;
      end
    end
  end
endmodule
